// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit holding HI/LO for the EX stage.
// Arithmetic ops run for a fixed, parameterised number of busy cycles; mthi/mtlo write immediately.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mduOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state  | meaning
    // S_IDLE | accepting requests, mthi/mtlo write directly
    // S_RUN  | arithmetic op in flight, counter running, requests ignored

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_signed;
    logic [2*WIDTH-1:0]   ext_a, ext_b, prod, res;
    logic signed [WIDTH-1:0] sa, sb, sq, sr;
    logic [WIDTH-1:0]     uq, ur;

    assign is_signed = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                       (op_q == OP_MSUB) || (op_q == OP_DIV);

    assign ext_a = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2W bits of the extended product are correct for both signednesses.
    assign prod  = ext_a * ext_b;

    assign sa = a_q;
    assign sb = b_q;
    assign sq = sa / sb;
    assign sr = sa % sb;
    assign uq = a_q / b_q;
    assign ur = a_q % b_q;

    always_comb begin
        res = prod;
        case (op_q)
            OP_MADD, OP_MADDU: res = acc_q + prod;
            OP_MSUB, OP_MSUBU: res = acc_q - prod;
            OP_DIV: begin
                if (b_q == '0)
                    res = {a_q, ALL_ONES};
                else if ((a_q == MIN_INT) && (b_q == ALL_ONES))
                    res = {{WIDTH{1'b0}}, MIN_INT};
                else
                    res = {sr, sq};
            end
            OP_DIVU: begin
                if (b_q == '0)
                    res = {a_q, ALL_ONES};
                else
                    res = {ur, uq};
            end
            default: res = prod;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mduOp)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            op_d    = mduOp;
                            a_d     = srcA;
                            b_d     = srcB;
                            acc_d   = {hi_q, lo_q};
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = mduOp;
                            a_d     = srcA;
                            b_d     = srcB;
                            acc_d   = {hi_q, lo_q};
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = srcA;
                        OP_MTLO: lo_d = srcA;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Counter holds the number of busy cycles left including the current one.
                if (cnt_q == CW'(1)) begin
                    hi_d    = res[2*WIDTH-1:WIDTH];
                    lo_d    = res[WIDTH-1:0];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: a 32-bit default instance and a 16-bit single-cycle-multiply instance.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, busy0, done0;
    logic [3:0]  op0 = '0;
    logic [31:0] a0 = '0, b0 = '0, hi0, lo0;

    logic        start1 = 1'b0, busy1, done1;
    logic [3:0]  op1 = '0;
    logic [15:0] a1 = '0, b1 = '0, hi1, lo1;

    mdu_seq u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mduOp(op0),
        .srcA(a0), .srcB(b0), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    mdu_seq #(.WIDTH(16), .MULT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .mduOp(op1),
        .srcA(a1), .srcB(b1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] q0[$];
    logic [31:0] q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Result monitors: pop and compare whenever a DUT flags a new result.
    always @(negedge clk) begin
        if (done0) begin
            logic [63:0] e;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_done actual=%h expected=none", {hi0, lo0});
            end else begin
                e = q0.pop_front();
                if ({hi0, lo0} !== e) begin
                    errors++;
                    $display("FAIL dut0_result actual=%h expected=%h", {hi0, lo0}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            logic [31:0] e;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_done actual=%h expected=none", {hi1, lo1});
            end else begin
                e = q1.pop_front();
                if ({hi1, lo1} !== e) begin
                    errors++;
                    $display("FAIL dut1_result actual=%h expected=%h", {hi1, lo1}, e);
                end
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge of the done cycle.
    task automatic run_op(input int sel, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_n, input bit poke);
        int n;
        bit hold_ok;
        logic [63:0] snap;
        if (sel == 0) begin
            start0 = 1'b1; op0 = op; a0 = a; b0 = b;
            q0.push_back(exp);
        end else begin
            start1 = 1'b1; op1 = op; a1 = a[15:0]; b1 = b[15:0];
            q1.push_back(exp[31:0]);
        end
        @(negedge clk);
        if (sel == 0) begin
            start0 = 1'b0; a0 = ~a; b0 = ~b;
            snap = {hi0, lo0};
        end else begin
            start1 = 1'b0; a1 = ~a[15:0]; b1 = ~b[15:0];
            snap = {32'h0, hi1, lo1};
        end
        n = 0;
        hold_ok = 1'b1;
        while (((sel == 0) ? busy0 : busy1) && n < 50) begin
            n++;
            if (((sel == 0) ? {hi0, lo0} : {32'h0, hi1, lo1}) !== snap) hold_ok = 1'b0;
            if (poke && n == 2) begin
                start0 = 1'b1; op0 = 4'd9; a0 = 32'h0000AAAA;
            end else if (poke && n == 3) begin
                start0 = 1'b0;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        if (n >= 50) begin
            errors++;
            $display("FAIL busy_timeout op=%0d actual=%0d expected=%0d", op, n, exp_n);
        end
        check($sformatf("busy_cycles_op%0d", op), 64'(n), 64'(exp_n));
        check($sformatf("hold_op%0d", op), {63'h0, hold_ok}, 64'h1);
        check($sformatf("done_pulse_op%0d", op), {63'h0, (sel == 0) ? done0 : done1}, 64'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_dut0", {busy0, done0, hi0, lo0}, 66'h0);
        check("reset_dut1", {30'h0, busy1, done1, hi1, lo1}, 64'h0);

        run_op(0, 4'd1, 32'hFFFFFFFF, 32'h2,        64'hFFFFFFFF_FFFFFFFE, 5, 0);
        run_op(0, 4'd2, 32'hFFFFFFFF, 32'h2,        64'h00000001_FFFFFFFE, 5, 0);
        run_op(0, 4'd6, 32'h00010000, 32'h00010000, 64'h00000002_FFFFFFFE, 5, 0);
        run_op(0, 4'd7, 32'h3,        32'hFFFFFFFF, 64'h00000003_00000001, 5, 0);
        run_op(0, 4'd8, 32'h1,        32'h2,        64'h00000002_FFFFFFFF, 5, 0);
        run_op(0, 4'd5, 32'hFFFFFFFF, 32'h1,        64'h00000002_FFFFFFFE, 5, 0);
        run_op(0, 4'd3, 32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 10, 0);
        run_op(0, 4'd4, 32'hFFFFFFF9, 32'h2,        64'h00000001_7FFFFFFC, 10, 0);
        run_op(0, 4'd3, 32'h00001234, 32'h0,        64'h00001234_FFFFFFFF, 10, 0);
        run_op(0, 4'd4, 32'h00000005, 32'h0,        64'h00000005_FFFFFFFF, 10, 0);
        run_op(0, 4'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 0);
        run_op(0, 4'd1, 32'h3,        32'h4,        64'h00000000_0000000C, 5, 1);

        @(negedge clk);
        start0 = 1'b1; op0 = 4'd9; a0 = 32'h0000AAAA;
        @(negedge clk);
        start0 = 1'b0;
        check("mthi_idle", {busy0, hi0, lo0}, {1'b0, 32'h0000AAAA, 32'h0000000C});
        start0 = 1'b1; op0 = 4'd10; a0 = 32'h00005555;
        @(negedge clk);
        start0 = 1'b0;
        check("mtlo_idle", {busy0, hi0, lo0}, {1'b0, 32'h0000AAAA, 32'h00005555});
        start0 = 1'b1; op0 = 4'd12; a0 = 32'h0; b0 = 32'h0;
        @(negedge clk);
        start0 = 1'b0;
        check("reserved_op", {busy0, hi0, lo0}, {1'b0, 32'h0000AAAA, 32'h00005555});

        run_op(0, 4'd6, 32'h1, 32'h1, 64'h0000AAAA_00005556, 5, 0);

        start0 = 1'b1; op0 = 4'd3; a0 = 32'h64; b0 = 32'h7;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_div", {busy0, done0, hi0, lo0}, 66'h0);
        start0 = 1'b1; op0 = 4'd9; a0 = 32'h0000AAAA;
        @(negedge clk);
        reset = 1'b0; start0 = 1'b0;
        check("reset_beats_start", {busy0, hi0, lo0}, 65'h0);
        repeat (15) @(negedge clk);
        check("no_done_after_reset", {busy0, hi0, lo0}, 65'h0);

        run_op(0, 4'd1, 32'h3, 32'h4, 64'h00000000_0000000C, 5, 0);

        run_op(1, 4'd1, 32'h0000FFFF, 32'h00000003, 64'h00000000_FFFFFFFD, 1, 0);
        run_op(1, 4'd2, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000_FFFE0001, 1, 0);

        repeat (3) @(negedge clk);
        check("queue0_drained", 64'(q0.size()), 64'h0);
        check("queue1_drained", 64'(q1.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised sequential multiply/divide unit for the pipelined CPU, sitting in the EX stage beside the ALU. It holds the HI/LO pair, runs multiply, divide and multiply-accumulate operations over a configurable number of cycles, and reports `busy`. The hazard logic uses `busy` to stall dependent MDU instructions. It supersedes the fixed single-width MDU and adds accumulate/subtract modes, configurable latency, and defined divide-by-zero behaviour.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width.
- `MULT_CYCLES`, default 5: busy cycles for mult/madd/msub ops. Must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div ops. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe, sampled on the rising edge.
- `mduOp`  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11–15 reserved.
- `srcA`  in  WIDTH  rs operand.
- `srcB`  in  WIDTH  rt operand; ignored by mthi/mtlo.
- `busy`  out  1  an arithmetic operation is in flight.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a new arithmetic result.
- `hi`  out  WIDTH  current HI register, for mfhi.
- `lo`  out  WIDTH  current LO register, for mflo.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0. The cycle counter is cleared and any in-flight operation is discarded.
- **IDLE** state:
  - `start` with ops 1–8: latch `srcA`, `srcB`, op and the current `{hi,lo}`. Load counter with MULT_CYCLES (ops 1,2,5–8) or DIV_CYCLES (ops 3,4), then go to RUN.
  - `start` with op 9: `hi` ← `srcA` at that edge; no busy.
  - `start` with op 10: `lo` ← `srcA` at that edge; no busy.
  - `start` with op 0 or 11–15: no effect.
- **RUN** state:
  - `busy`=1. The counter decrements each cycle.
  - At the edge where the counter expires, write the result to `{hi,lo}`, return to IDLE, and set `done`=1 for the following cycle.
- `start` during RUN, including mthi/mtlo, is ignored entirely. The hazard unit is required to stall these.
- Arithmetic. All products are 2·WIDTH wide; {hi,lo} is treated as a 2·WIDTH value and wraps modulo 2^(2·WIDTH).
  - mult: {hi,lo} = signed(A)·signed(B).
  - multu: {hi,lo} = unsigned(A)·unsigned(B).
  - madd / maddu: {hi,lo} = {hi,lo}_latched + product (signed / unsigned).
  - msub / msubu: {hi,lo} = {hi,lo}_latched − product (signed / unsigned).
  - div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
- Division boundaries:
  - B=0, div or divu: lo = all ones, hi = A.
  - div with A=MIN_INT and B=−1: lo = MIN_INT, hi = 0.
- Operands are captured at start; later changes on `srcA`/`srcB` do not affect the result.
- `hi`/`lo` hold their old values for the whole RUN period. They are registered outputs, never driven combinationally from the inputs.
- Internal datapath is free (iterative or a single-cycle result held in a register), but the observable latency is exactly as specified under Timing.

## Timing
- Arithmetic op sampled with `start` at edge t:
  - `busy`=1 during cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - `hi`/`lo` take the new value, and `done`=1, in cycle t+N+1.
  - `busy`=0 in cycle t+N+1.
- A new `start` is accepted at edge t+N+1, i.e. the first edge where `busy`=0. Back-to-back operations therefore have zero gap cycles.
- mthi/mtlo sampled at edge t: the new value is visible in cycle t+1; `busy` and `done` stay 0.
- Reset asserted at any edge during RUN: the next cycle shows `busy`=0, `hi`=`lo`=0, `done`=0. No result is ever written.
- Reset and `start` at the same edge: reset wins; the request is dropped.

## Test plan
- Reset, then mult with A=0xFFFFFFFF, B=2 (defaults) → `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` pulses once.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE. Then maddu with A=B=0x00010000 → hi=0x00000002, lo=0xFFFFFFFE.
- div with A=−7, B=2 → after 10 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- div with B=0 and A=0x1234 → lo=0xFFFFFFFF, hi=0x1234. Then div with A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi 0xAAAA during RUN of a mult → write ignored and hi ends at the mult result. The same mthi while idle → hi=0xAAAA next cycle, `busy` stays 0.
- Reset asserted in the 3rd busy cycle of a div → next cycle `busy`=0, hi=lo=0, no `done`. Repeat mult with WIDTH=16, MULT_CYCLES=1 → one busy cycle, correct 32-bit {hi,lo}.
